mod_counter: RTL and testbench

Parametrised modulo up/down counter with a built-in clock-enable prescaler, synchronous load, terminal-count pulse and sticky overflow flag. It is the generalised successor to the fixed 9-bit free-running adder-plus-register counter. It drives the display path: `count` feeds the 7-segment digit decoder, and `terminal` cascades into a further counter stage.

---
 rtl/mod_counter.sv | 145 ++++++++++++++
 tb/tb_mod_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised modulo up/down counter with prescaler, load, terminal pulse and sticky overflow
//
// Purpose:
//   Modulo-MODULO up/down counter. It steps once every PRESCALE enabled cycles.
//   - A synchronous load has priority over a step.
//   - A wrap event (or a blocked step in saturating mode) produces a one-cycle
//     registered terminal pulse and sets a sticky overflow flag.
//   - count feeds the 7-segment digit decoder; terminal cascades into a
//     following counter stage.
//
// Optional feature macro: MOD_COUNTER_SATURATE_EN
//   Defined   : the counter saturates at MODULO-1 (up) and 0 (down). Each blocked
//               step is a saturate event.
//   Undefined : the counter wraps around (default).
//
// Parameters:
//   WIDTH    - counter width in bits
//   MODULO   - count range 0..MODULO-1, 2 <= MODULO <= 2**WIDTH
//   PRESCALE - enabled cycles per count step, >= 1
//
// Ports:
//   system_clock  in   1      rising-edge clock
//   system_reset  in   1      synchronous active-high reset
//   enable        in   1      advances the prescaler; counter holds while low
//   up_down       in   1      1 = count up, 0 = count down (sampled on tick)
//   load          in   1      synchronous load request
//   load_value    in   WIDTH  value to load (out-of-range values load 0)
//   clear_ovf     in   1      clears overflow (a same-edge event wins)
//   count         out  WIDTH  registered counter value
//   tick          out  1      combinational step strobe
//   terminal      out  1      one-cycle pulse after a wrap/saturate event
//   overflow      out  1      sticky wrap/saturate flag

module mod_counter #(
  parameter int WIDTH    = 9,
  parameter int MODULO   = 2**WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             system_clock,
  input  logic             system_reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             terminal,
  output logic             overflow
);

  // The prescaler needs at least one bit, even when PRESCALE = 1.
  localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);

  // MODULO may equal 2**WIDTH. It is held at WIDTH+1 bits so that the load
  // range check still works in that case.
  localparam logic [WIDTH:0]    MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0]  CNT_MAX = WIDTH'(MODULO - 1);

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             terminal_q, terminal_d;
  logic             overflow_q, overflow_d;

  logic             ps_last;
  logic             tick_s;
  logic             at_max;
  logic             at_min;
  logic             limit_hit;
  logic             load_in_range;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;

  assign ps_last = (ps_q == PS_LAST);

  // A load on the tick cycle takes the edge, so the strobe is suppressed.
  // Reset also masks it so that no pulse leaks out while held in reset.
  assign tick_s = ~system_reset & enable & ps_last & ~load;

  assign at_max    = (count_q == CNT_MAX);
  assign at_min    = (count_q == '0);
  assign limit_hit = up_down ? at_max : at_min;

  assign load_in_range = ({1'b0, load_value} < MOD_EXT);

  // The step arithmetic is done at WIDTH+1 bits and truncated.
  // The carry/borrow is ignored because the wrap decision comes only from
  // the at_max/at_min compares.
  assign count_inc = WIDTH'({1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1});
  assign count_dec = WIDTH'({1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1});

  always_comb begin
    ps_d       = ps_q;
    count_d    = count_q;
    terminal_d = 1'b0;
    overflow_d = overflow_q & ~clear_ovf;

    if (load) begin
      // A load restarts the prescaler phase and is never a wrap event.
      ps_d    = '0;
      count_d = load_in_range ? load_value : '0;
    end else begin
      if (enable) begin
        ps_d = ps_last ? '0 : ps_q + 1'b1;
      end

      if (tick_s) begin
        if (limit_hit) begin
          // The event sets overflow after the clear term above, so a
          // same-edge clear_ovf loses.
          terminal_d = 1'b1;
          overflow_d = 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
          count_d    = count_q;
`else
          count_d    = up_down ? '0 : CNT_MAX;
`endif
        end else begin
          count_d = up_down ? count_inc : count_dec;
        end
      end
    end
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      ps_q       <= '0;
      count_q    <= '0;
      terminal_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      count_q    <= count_d;
      terminal_q <= terminal_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign tick     = tick_s;
  assign terminal = terminal_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - self-checking bench for mod_counter (two configurations, shared stimulus)

module tb_mod_counter;

`ifdef MOD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, up, ld, clr;
  logic [3:0] lv;

  logic [3:0] cnt_a, cnt_b;
  logic       tick_a, tick_b, term_a, term_b, ovf_a, ovf_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) dut_a (
    .system_clock(clk), .system_reset(rst), .enable(en), .up_down(up),
    .load(ld), .load_value(lv), .clear_ovf(clr),
    .count(cnt_a), .tick(tick_a), .terminal(term_a), .overflow(ovf_a)
  );

  mod_counter #(.WIDTH(4), .MODULO(16), .PRESCALE(1)) dut_b (
    .system_clock(clk), .system_reset(rst), .enable(en), .up_down(up),
    .load(ld), .load_value(lv), .clear_ovf(clr),
    .count(cnt_b), .tick(tick_b), .terminal(term_b), .overflow(ovf_b)
  );

  // Reference model, one entry per instance.
  int MODS [2] = '{10, 16};
  int PRES [2] = '{3, 1};
  int m_cnt [2];
  int m_ps  [2];
  int m_term[2];
  int m_ovf [2];
  bit armed = 1'b0;

  function automatic bit exp_tick(input int i);
    return en && (m_ps[i] == PRES[i] - 1) && !ld && !rst;
  endfunction

  task automatic pin(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit tk;
      bit ev;
      tk = exp_tick(i);
      ev = 1'b0;
      if (rst) begin
        m_cnt[i] = 0; m_ps[i] = 0; m_term[i] = 0; m_ovf[i] = 0;
        armed = 1'b1;
      end else if (ld) begin
        m_cnt[i]  = (int'(lv) < MODS[i]) ? int'(lv) : 0;
        m_ps[i]   = 0;
        m_term[i] = 0;
        if (clr) m_ovf[i] = 0;
      end else begin
        if (en) m_ps[i] = (m_ps[i] + 1) % PRES[i];
        if (tk) begin
          if (up) begin
            if (m_cnt[i] == MODS[i] - 1) begin
              ev = 1'b1;
              if (!SAT) m_cnt[i] = 0;
            end else m_cnt[i] = m_cnt[i] + 1;
          end else begin
            if (m_cnt[i] == 0) begin
              ev = 1'b1;
              if (!SAT) m_cnt[i] = MODS[i] - 1;
            end else m_cnt[i] = m_cnt[i] - 1;
          end
        end
        m_term[i] = ev ? 1 : 0;
        if (ev) m_ovf[i] = 1;
        else if (clr) m_ovf[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      pin("a.count",    int'(cnt_a),  m_cnt[0]);
      pin("a.tick",     int'(tick_a), int'(exp_tick(0)));
      pin("a.terminal", int'(term_a), m_term[0]);
      pin("a.overflow", int'(ovf_a),  m_ovf[0]);
      pin("b.count",    int'(cnt_b),  m_cnt[1]);
      pin("b.tick",     int'(tick_b), int'(exp_tick(1)));
      pin("b.terminal", int'(term_b), m_term[1]);
      pin("b.overflow", int'(ovf_b),  m_ovf[1]);
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int terms;

  initial begin
    rst = 1; en = 1; up = 1; ld = 0; clr = 0; lv = 0;
    go(1);
    @(negedge clk);
    pin("rst count", int'(cnt_a), 0);
    pin("rst tick", int'(tick_a), 0);
    pin("rst ovf", int'(ovf_a), 0);
    pin("rst term", int'(term_a), 0);
    go(1); rst = 0;                               // cycle 1 after release
    @(negedge clk); pin("c1 tick", int'(tick_a), 0);
    go(1); @(negedge clk); pin("c2 tick", int'(tick_a), 0);
    go(1); @(negedge clk); pin("c3 tick", int'(tick_a), 1);
    pin("c3 count", int'(cnt_a), 0);
    go(13); @(negedge clk); pin("b c16 count", int'(cnt_b), 15);
    go(1); @(negedge clk);
    pin("b c17 count", int'(cnt_b), SAT ? 15 : 0);
    pin("b c17 term", int'(term_b), 1);
    pin("b c17 ovf", int'(ovf_b), 1);
    go(11); @(negedge clk); pin("a c28 count", int'(cnt_a), 9);
    go(3); @(negedge clk);
    pin("up wrap count", int'(cnt_a), SAT ? 9 : 0);
    pin("up wrap term", int'(term_a), 1);
    pin("up wrap ovf", int'(ovf_a), 1);
    go(1); ld = 1; lv = 0; up = 0; clr = 1;       // c32
    @(negedge clk); pin("term width", int'(term_a), 0);
    go(1); ld = 0; clr = 0;                       // c33
    @(negedge clk);
    pin("load0 count", int'(cnt_a), 0);
    pin("clr ovf", int'(ovf_a), 0);
    pin("load0 tick", int'(tick_a), 0);
    go(1); @(negedge clk);                        // c34
    pin("b down wrap", int'(cnt_b), SAT ? 0 : 15);
    go(1); @(negedge clk); pin("a c35 tick", int'(tick_a), 1);
    go(1); @(negedge clk);                        // c36
    pin("down wrap count", int'(cnt_a), SAT ? 0 : 9);
    pin("down wrap term", int'(term_a), 1);
    pin("down wrap ovf", int'(ovf_a), 1);
    go(2); ld = 1; lv = 7;                        // c38, tick cycle
    @(negedge clk); pin("load masks tick", int'(tick_a), 0);
    go(1); ld = 0;                                // c39
    @(negedge clk); pin("load7 count", int'(cnt_a), 7);
    go(2); @(negedge clk); pin("tick after load", int'(tick_a), 1);
    go(1); ld = 1; lv = 12;                       // c42
    @(negedge clk); pin("step after load", int'(cnt_a), 6);
    go(1); ld = 1; lv = 9; up = 1;                // c43
    @(negedge clk);
    pin("load12 a", int'(cnt_a), 0);
    pin("load12 b", int'(cnt_b), 12);
    go(1); ld = 0;                                // c44
    @(negedge clk); pin("load9 count", int'(cnt_a), 9);
    go(2); clr = 1;                               // c46, wrap edge
    @(negedge clk); pin("c46 tick", int'(tick_a), 1);
    go(1);                                        // c47
    @(negedge clk);
    pin("set wins ovf", int'(ovf_a), 1);
    pin("set wins count", int'(cnt_a), SAT ? 9 : 0);
    go(1); clr = 0; ld = 1; lv = 9;               // c48
    @(negedge clk); pin("clear alone ovf", int'(ovf_a), 0);
    go(1); ld = 0;                                // c49
    terms = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      terms += int'(term_a);
      if (k < 9) go(1);
    end
    pin("3 ticks count", int'(cnt_a), SAT ? 9 : 2);
    pin("3 ticks pulses", terms, SAT ? 3 : 1);
    pin("3 ticks ovf", int'(ovf_a), 1);
    go(1); ld = 1; lv = 0; up = 0;                // c59
    go(1); ld = 0;                                // c60
    go(3); @(negedge clk);                        // c63
    pin("down from 0", int'(cnt_a), SAT ? 0 : 9);

    for (int k = 0; k < 200; k++) begin
      go(1);
      en  = ($urandom % 4) != 0;
      up  = $urandom % 2;
      ld  = ($urandom % 16) == 0;
      lv  = 4'($urandom);
      clr = ($urandom % 8) == 0;
      rst = ($urandom % 64) == 0;
    end
    go(1); rst = 0; ld = 0;
    go(2);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
